bus_fifo: RTL and testbench
===========================

// Module: bus_fifo
// PURPOSE
//  Elastic stage directly downstream of the bus buffer. Accepts words on a bus.i
//  interface with a valid/ready handshake and stores them in a DEPTH-entry FIFO.
//  Presents them first-word-fall-through on a bus.o interface with valid/ready.
//  Decouples the registered bus stage from consumers that stall.
// PARAMETERS
//  DEPTH  default 4  number of entries; power of 2, >= 2
//  DW     (localparam, = i.DW)  data width, taken from the connected interface
// PORTS
//  clk    input   1              system clock, all logic on rising edge
//  rst    input   1              asynchronous reset, active-low
//  i      bus.i   DW             write data (i.dat)
//  i_vld  input   1              i.dat valid
//  i_rdy  output  1              FIFO can accept a word
//  o      bus.o   DW             read data (o.dat), head of FIFO
//  o_vld  output  1              o.dat valid (FIFO not empty)
//  o_rdy  input   1              consumer takes head word
//  cnt    output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//  ovf    output  1              sticky overflow flag (only with BUS_FIFO_OVF_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, cnt=0, o_vld=0, o.dat='0,
//    i_rdy=0 while rst is low, ovf=0. Storage array is not reset.
//  - States by cnt: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
//  - i_rdy = rst & (cnt != DEPTH); o_vld = (cnt != 0). Both are decoded from
//    registered state only, with no combinational path from i_vld/o_rdy.
//  - Write when i_vld & i_rdy: mem[wr_ptr] <= i.dat; wr_ptr++ mod DEPTH.
//  - Read when o_vld & o_rdy: rd_ptr++ mod DEPTH.
//  - o.dat = mem[rd_ptr] when o_vld, else '0 (FWFT, combinational read).
//  - Latency: a word written at edge k is on o.dat with o_vld=1 after edge k.
//    It is consumable in cycle k+1. Minimum latency 1 cycle, no bypass.
//  - cnt: +1 on write only, -1 on read only, unchanged on both or neither.
//  - Simultaneous write and read in PARTIAL: both happen, cnt unchanged.
//  - FULL: i_rdy=0, so no write; a read in the same cycle frees a slot.
//    i_rdy rises the next cycle, with no same-cycle pass-through.
//  - EMPTY: o_vld=0, o_rdy ignored; a write the same cycle gives o_vld=1 next cycle.
//  - Pointer wrap: DEPTH-1 -> 0; cnt never exceeds DEPTH or underflows.
//  - Reset asserted mid-operation: all content is discarded immediately.
//    After release, the FIFO is EMPTY and i_rdy=1 on the first cycle.
//  - Upstream must hold i.dat/i_vld stable while i_vld & !i_rdy.
// CONFIGURATION
//  BUS_FIFO_OVF_EN defined:
//    - port ovf exists.
//    - ovf <= 1 at any edge where rst=1 & i_vld=1 & cnt==DEPTH.
//    - ovf is sticky; only reset clears it.
//  BUS_FIFO_OVF_EN undefined:
//    - port ovf and its flop are absent.
//    - i_vld while FULL is simply not accepted, with no indication.
// TESTING (DW=4, DEPTH=4)
//  - Reset: rst=0 then release -> cnt=0, o_vld=0, o.dat=0, i_rdy=1.
//  - Fill: write 1,2,3,4 with o_rdy=0 -> cnt=4, i_rdy=0.
//    A 5th word (5) is not stored; ovf=1 if the macro is defined.
//  - Drain: then o_rdy=1 -> o.dat sequence 1,2,3,4, then o_vld=0, cnt=0.
//  - Streaming: i_vld=o_rdy=1 for 10 cycles with i.dat=cnt[3:0].
//    -> output equals input delayed 1 cycle, cnt stays 1, pointers wrap twice.
//  - Full plus read: FULL state, i_vld=1, o_rdy=1 for 1 cycle.
//    -> head popped, no write that cycle, cnt=3, i_rdy=1 next cycle.
//  - Mid-op reset: cnt=2, pulse rst low between edges.
//    -> o_vld=0 and cnt=0 asynchronously; ovf cleared; old data never reappears.

Source files
------------

// File: rtl/bus_fifo_if.sv
// Word-carrying bus interface used on both sides of bus_fifo.
// Port i is the write side and port o is the read side; DW sets the data width.
interface bus #(
    parameter int DW = 8
);
    logic [DW-1:0] dat;

    modport i (input  dat);
    modport o (output dat);
endinterface

// File: rtl/bus_fifo.sv
// bus_fifo: elastic FWFT FIFO with valid/ready on both sides, placed after the bus buffer.
// Optional sticky overflow flag `ovf` when BUS_FIFO_OVF_EN is defined.
//
// state   | meaning
// EMPTY   | cnt == 0, o_vld low, o_rdy ignored
// PARTIAL | 0 < cnt < DEPTH, write and read may both happen
// FULL    | cnt == DEPTH, i_rdy low, a read frees a slot for the next cycle
module bus_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    bus.i                            i,
    input  logic                     i_vld,
    output logic                     i_rdy,
    bus.o                            o,
    output logic                     o_vld,
    input  logic                     o_rdy,
`ifdef BUS_FIFO_OVF_EN
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ovf
`else
    output logic [$clog2(DEPTH):0]   cnt
`endif
);
    localparam int DW = $bits(i.dat);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Handshake flags come only from registered cnt and the reset pin.
    assign i_rdy = rst & (cnt != FULL_CNT);
    assign o_vld = (cnt != '0);
    assign wr_en = i_vld & i_rdy;
    assign rd_en = o_vld & o_rdy;
    assign o.dat = o_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= i.dat;
    end

`ifdef BUS_FIFO_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (i_vld && (cnt == FULL_CNT)) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo (DW=4, DEPTH=4) using a queue scoreboard.
// Optional ovf checks follow BUS_FIFO_OVF_EN.
module tb_bus_fifo;
    logic       clk;
    logic       rst;
    logic       i_vld;
    logic       i_rdy;
    logic       o_vld;
    logic       o_rdy;
    logic [2:0] cnt;
`ifdef BUS_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_m;
`endif

    bus #(.DW(4)) bi ();
    bus #(.DW(4)) bo ();

    bus_fifo #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .i     (bi),
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .o     (bo),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
`ifdef BUS_FIFO_OVF_EN
        .cnt   (cnt),
        .ovf   (ovf)
`else
        .cnt   (cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check against the model at negedge, advance the model after the edge.
    task automatic cyc(input logic v, input logic [3:0] d, input logic r);
        logic acc;
        logic pop;
        i_vld  = v;
        bi.dat = d;
        o_rdy  = r;
        @(negedge clk);
        check_eq("cnt", 32'(cnt), 32'(sb.size()));
        check_eq("i_rdy", 32'(i_rdy), 32'(sb.size() != 4));
        check_eq("o_vld", 32'(o_vld), 32'(sb.size() != 0));
        if (sb.size() != 0) check_eq("o_dat", 32'(bo.dat), 32'(sb[0]));
        else                check_eq("o_dat_idle", 32'(bo.dat), 32'(0));
`ifdef BUS_FIFO_OVF_EN
        check_eq("ovf", 32'(ovf), 32'(ovf_m));
        if (v && sb.size() == 4) ovf_m = 1'b1;
`endif
        acc = v && (sb.size() < 4);
        pop = r && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back(d);
    endtask

    initial begin
        rst    = 1'b0;
        i_vld  = 1'b0;
        o_rdy  = 1'b0;
        bi.dat = '0;
`ifdef BUS_FIFO_OVF_EN
        ovf_m  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cnt", 32'(cnt), 32'(0));
        check_eq("rst_o_vld", 32'(o_vld), 32'(0));
        check_eq("rst_o_dat", 32'(bo.dat), 32'(0));
        check_eq("rst_i_rdy", 32'(i_rdy), 32'(0));
        rst = 1'b1;
        #1;
        check_eq("rel_i_rdy", 32'(i_rdy), 32'(1));

        // Fill, overfill attempt, drain
        for (int k = 1; k <= 4; k++) cyc(1'b1, 4'(k), 1'b0);
        check_eq("full_cnt", 32'(cnt), 32'(4));
        cyc(1'b1, 4'd5, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 4'd0, 1'b1);
        check_eq("drained_cnt", 32'(cnt), 32'(0));

        // Streaming through wrap
        for (int k = 0; k < 10; k++) cyc(1'b1, 4'(k + 6), 1'b1);
        check_eq("stream_cnt", 32'(cnt), 32'(1));
        cyc(1'b0, 4'd0, 1'b1);

        // Full plus read
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'(4'hA + k), 1'b0);
        cyc(1'b1, 4'hF, 1'b1);
        check_eq("fpr_cnt", 32'(cnt), 32'(3));
        check_eq("fpr_i_rdy", 32'(i_rdy), 32'(1));
        cyc(1'b1, 4'h3, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'd0, 1'b1);

        // Mid-operation reset with two words held
        cyc(1'b1, 4'h7, 1'b0);
        cyc(1'b1, 4'h8, 1'b0);
        i_vld = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_eq("mrst_o_vld", 32'(o_vld), 32'(0));
        check_eq("mrst_cnt", 32'(cnt), 32'(0));
        check_eq("mrst_i_rdy", 32'(i_rdy), 32'(0));
`ifdef BUS_FIFO_OVF_EN
        check_eq("mrst_ovf", 32'(ovf), 32'(0));
        ovf_m = 1'b0;
`endif
        #1;
        rst = 1'b1;
        sb.delete();
        cyc(1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b1, 4'h9, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
